// File: rtl/aurora_hls_nfc_arbiter_if.sv
// Aurora native-flow-control AXI-Stream channel.
//   tvalid  master -> slave   message valid
//   tready  slave  -> master  message accepted
//   tdata   master -> slave   NFC word, big-endian, ffff = XOFF, 0000 = XON
interface aurora_hls_nfc_arbiter_if;
   logic        tvalid;
   logic        tready;
   logic [0:15] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/aurora_hls_nfc_arbiter.sv
// Shares one Aurora NFC port among NUM_SRC pause requesters. Sends XOFF when any
// requester wants a pause and XON only when all have released. Enforces a minimum
// gap between messages and re-sends XOFF periodically while paused.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   src_xoff_req        per-source pause request level
//   m_nfc               NFC stream master (tvalid/tready/tdata)
//   paused              1 after XOFF handshake, 0 after XON handshake
//   pause_owner_mask    sticky OR of requests since the last XON handshake
//   xoff_count          request-caused XOFF handshakes
//   refresh_count       refresh-caused XOFF handshakes
//   xon_count           XON handshakes
//
// state      | meaning
// S_INIT     | one cycle after reset, chooses the first message
// S_RUN      | link running, waiting for a request and gap expiry
// S_SEND_XOFF| presenting ffff until accepted
// S_PAUSED   | link paused, waiting for release or refresh
// S_SEND_XON | presenting 0000 until accepted
module aurora_hls_nfc_arbiter #(
   parameter int NUM_SRC        = 4,
   parameter int MIN_GAP        = 16,
   parameter int REFRESH_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SRC-1:0]      src_xoff_req,
   aurora_hls_nfc_arbiter_if.master m_nfc,
   output logic                    paused,
   output logic [NUM_SRC-1:0]      pause_owner_mask,
   output logic [31:0]             xoff_count,
   output logic [31:0]             refresh_count,
   output logic [31:0]             xon_count
);

   localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
   localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);
   localparam logic [TW-1:0] REF_LAST = (REFRESH_CYCLES > 0) ? TW'(REFRESH_CYCLES - 1) : '0;
   localparam logic [0:15]   XOFF_WORD = 16'hffff;
   localparam logic [0:15]   XON_WORD  = 16'h0000;

   typedef enum logic [2:0] {
      S_INIT,
      S_RUN,
      S_SEND_XOFF,
      S_PAUSED,
      S_SEND_XON
   } state_t;

   state_t               state, state_d;
   logic [NUM_SRC-1:0]   req_q;
   logic [GW-1:0]        gap;
   logic [TW-1:0]        timer;
   logic                 is_refresh, is_refresh_d;
   logic                 tvalid_d;
   logic [0:15]          tdata_d;
   logic                 agg;
   logic                 gap_zero;
   logic                 refresh_due;
   logic                 hs;
   logic                 xoff_hs;
   logic                 xon_hs;

   assign agg         = |req_q;
   assign gap_zero    = (gap == '0);
   assign refresh_due = (REFRESH_CYCLES != 0) && (timer >= REF_LAST) && gap_zero && agg;
   assign hs          = m_nfc.tvalid && m_nfc.tready;
   assign xoff_hs     = hs && (state == S_SEND_XOFF);
   assign xon_hs      = hs && (state == S_SEND_XON);

   always_comb begin
      state_d      = state;
      tvalid_d     = m_nfc.tvalid;
      tdata_d      = m_nfc.tdata;
      is_refresh_d = is_refresh;
      case (state)
         S_INIT: begin
            tvalid_d = 1'b1;
            if (agg) begin
               state_d      = S_SEND_XOFF;
               tdata_d      = XOFF_WORD;
               is_refresh_d = 1'b0;
            end else begin
               state_d = S_SEND_XON;
               tdata_d = XON_WORD;
            end
         end
         S_RUN: begin
            if (agg && gap_zero) begin
               state_d      = S_SEND_XOFF;
               tvalid_d     = 1'b1;
               tdata_d      = XOFF_WORD;
               is_refresh_d = 1'b0;
            end
         end
         S_SEND_XOFF: begin
            if (hs) begin
               state_d  = S_PAUSED;
               tvalid_d = 1'b0;
            end
         end
         S_PAUSED: begin
            // release outranks refresh
            if (!agg && gap_zero) begin
               state_d  = S_SEND_XON;
               tvalid_d = 1'b1;
               tdata_d  = XON_WORD;
            end else if (refresh_due) begin
               state_d      = S_SEND_XOFF;
               tvalid_d     = 1'b1;
               tdata_d      = XOFF_WORD;
               is_refresh_d = 1'b1;
            end
         end
         S_SEND_XON: begin
            if (hs) begin
               state_d  = S_RUN;
               tvalid_d = 1'b0;
            end
         end
         default: begin
            state_d  = S_INIT;
            tvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= S_INIT;
         req_q            <= '0;
         m_nfc.tvalid     <= 1'b0;
         m_nfc.tdata      <= '0;
         is_refresh       <= 1'b0;
         gap              <= '0;
         timer            <= '0;
         paused           <= 1'b0;
         pause_owner_mask <= '0;
         xoff_count       <= '0;
         refresh_count    <= '0;
         xon_count        <= '0;
      end else begin
         state        <= state_d;
         req_q        <= src_xoff_req;
         m_nfc.tvalid <= tvalid_d;
         m_nfc.tdata  <= tdata_d;
         is_refresh   <= is_refresh_d;

         if (hs)
            gap <= GAP_LOAD;
         else if (!gap_zero)
            gap <= gap - 1'b1;

         if (xoff_hs)
            timer <= '0;
         else if ((state == S_PAUSED) && (timer != '1))
            timer <= timer + 1'b1;

         if (xoff_hs)
            paused <= 1'b1;
         else if (xon_hs)
            paused <= 1'b0;

         // clear on XON handshake wins over the same-cycle set
         if (xon_hs)
            pause_owner_mask <= '0;
         else
            pause_owner_mask <= pause_owner_mask | req_q;

         if (xoff_hs && !is_refresh)
            xoff_count <= xoff_count + 32'd1;
         if (xoff_hs && is_refresh)
            refresh_count <= refresh_count + 32'd1;
         if (xon_hs)
            xon_count <= xon_count + 32'd1;
      end
   end

endmodule
